// File: rtl/axi_lite_master_pkg.sv
// Shared AXI-Lite master types: response codes, FSM states, default address width.
// Latency: none (types only).
// Backpressure: n/a.
package lexington;

    localparam int DEFAULT_AXI_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } axi_state_t;

    // SLVERR and DECERR both carry bit 1; that bit alone flags a fault.
    function automatic logic resp_is_err(input axi_resp_t resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Bridges a level-request core port to a single-outstanding AXI-Lite master.
// Latency: request cycle 0, result (DONE) in cycle 3 at the earliest.
// Backpressure: core is stalled via axi_wait; every AXI valid is held until its handshake.
module axi_lite_master
    import lexington::*;
#(
    parameter int AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      axi_rd_en,
    input  logic                      axi_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_addr,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_strobe,
    output logic [31:0]               axi_rd_data,
    output logic                      axi_access_fault,
    output logic                      axi_wait,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [31:0]               m_wdata,
    output logic [3:0]                m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [31:0]               m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    axi_state_t                state;
    logic                      is_wr;
    logic                      aw_done;
    logic                      w_done;
    logic                      fault_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               data_q;
    logic [3:0]                strb_q;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic aw_fin;
    logic w_fin;

    assign aw_hs  = m_awvalid & m_awready;
    assign w_hs   = m_wvalid & m_wready;
    assign ar_hs  = m_arvalid & m_arready;
    // A channel counts as finished in the same cycle its handshake happens.
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_wdata  = data_q;
    assign m_wstrb  = strb_q;

    assign axi_wait         = (axi_rd_en | axi_wr_en) && (state != ST_DONE);
    assign axi_access_fault = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            is_wr       <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            fault_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            axi_rd_data <= '0;
            m_awvalid   <= 1'b0;
            m_wvalid    <= 1'b0;
            m_bready    <= 1'b0;
            m_arvalid   <= 1'b0;
            m_rready    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (axi_wr_en || axi_rd_en) begin
                        addr_q    <= axi_addr;
                        data_q    <= wr_data;
                        strb_q    <= wr_strobe;
                        is_wr     <= axi_wr_en;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        m_awvalid <= axi_wr_en;
                        m_wvalid  <= axi_wr_en;
                        m_arvalid <= ~axi_wr_en;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (is_wr) begin
                        if (aw_hs) begin
                            m_awvalid <= 1'b0;
                            aw_done   <= 1'b1;
                        end
                        if (w_hs) begin
                            m_wvalid <= 1'b0;
                            w_done   <= 1'b1;
                        end
                        if (aw_fin && w_fin) begin
                            m_bready <= 1'b1;
                            state    <= ST_RESP;
                        end
                    end else if (ar_hs) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (is_wr && m_bvalid && m_bready) begin
                        m_bready <= 1'b0;
                        fault_q  <= resp_is_err(axi_resp_t'(m_bresp));
                        state    <= ST_DONE;
                    end else if (!is_wr && m_rvalid && m_rready) begin
                        m_rready    <= 1'b0;
                        axi_rd_data <= m_rdata;
                        fault_q     <= resp_is_err(axi_resp_t'(m_rresp));
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    fault_q <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: table of directed transactions plus random ones,
// each checked cycle by cycle against a transaction-level model with a delay-driven slave.
module tb_axi_lite_master;
    import lexington::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        axi_rd_en = 1'b0;
    logic        axi_wr_en = 1'b0;
    logic [31:0] axi_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strobe = '0;
    logic [31:0] axi_rd_data;
    logic        axi_access_fault;
    logic        axi_wait;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = '0;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;

    always #5 clk = ~clk;

    axi_lite_master #(.AXI_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .axi_rd_en(axi_rd_en), .axi_wr_en(axi_wr_en), .axi_addr(axi_addr),
        .wr_data(wr_data), .wr_strobe(wr_strobe),
        .axi_rd_data(axi_rd_data), .axi_access_fault(axi_access_fault), .axi_wait(axi_wait),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rd = '0;

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          aw_d;
        int          w_d;
        int          ar_d;
        int          r_d;
        bit          drop;
        int          rst_cyc;
        logic        exp_fault;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                input logic [31:0] rdata, input logic [1:0] resp,
                                input int aw_d, input int w_d, input int ar_d, input int r_d,
                                input bit drop, input int rst_cyc, input logic exp_fault,
                                input logic [31:0] exp_rd, input int exp_lat);
        vec_t v;
        v.rd_en = rd; v.wr_en = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.rdata = rdata; v.resp = resp; v.aw_d = aw_d; v.w_d = w_d; v.ar_d = ar_d;
        v.r_d = r_d; v.drop = drop; v.rst_cyc = rst_cyc; v.exp_fault = exp_fault;
        v.exp_rd = exp_rd; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic clear_inputs();
        axi_rd_en = 1'b0; axi_wr_en = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bvalid = 1'b0; m_rvalid = 1'b0; m_bresp = '0; m_rresp = '0; m_rdata = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_awvalid"}, m_awvalid, 1'b0);
        chk({tag, "_wvalid"}, m_wvalid, 1'b0);
        chk({tag, "_arvalid"}, m_arvalid, 1'b0);
        chk({tag, "_bready"}, m_bready, 1'b0);
        chk({tag, "_rready"}, m_rready, 1'b0);
    endtask

    // Runs one transaction from its IDLE cycle (cycle 0) through its DONE cycle.
    task automatic run(input vec_t v);
        bit is_wr = v.wr_en;
        int aw_c = 0, w_c = 0, ar_c = 0, r_c = 0;
        int aw_n = 0, w_n = 0, ar_n = 0, resp_n = 0;
        int hs_cyc = -1;
        bit aw_pend = 0, w_pend = 0, ar_pend = 0, saw_ar = 0, finished = 0;
        bit phase, rv, done_now;
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                axi_rd_en = v.rd_en; axi_wr_en = v.wr_en; axi_addr = v.addr;
                wr_data = v.wdata; wr_strobe = v.strb;
            end
            if (v.drop && cyc >= 1) begin
                axi_rd_en = 1'b0; axi_wr_en = 1'b0;
            end
            if (cyc == v.rst_cyc) begin
                rst_n = 1'b0;
                clear_inputs();
                #1;
                check_idle_outputs("rst");
                chk("rst_rd_data", axi_rd_data, v.exp_rd);
                chk("rst_fault", axi_access_fault, 1'b0);
                model_rd = v.exp_rd;
                @(negedge clk);
                rst_n = 1'b1;
                finished = 1;
            end else begin
                phase = is_wr ? (aw_n > 0 && w_n > 0) : (ar_n > 0);
                m_awready = m_awvalid && (aw_c >= v.aw_d);
                m_wready  = m_wvalid && (w_c >= v.w_d);
                m_arready = m_arvalid && (ar_c >= v.ar_d);
                rv = phase && (resp_n == 0) && (r_c >= v.r_d);
                m_bvalid = is_wr && rv;
                m_rvalid = !is_wr && rv;
                m_bresp = v.resp; m_rresp = v.resp;
                m_rdata = rv ? v.rdata : 32'h0;
                #1;
                done_now = (hs_cyc >= 0) && (cyc == hs_cyc + 1);
                if (cyc == 0) check_idle_outputs("idle");
                if (aw_pend) chk("awvalid_hold", m_awvalid, 1'b1);
                if (w_pend)  chk("wvalid_hold", m_wvalid, 1'b1);
                if (ar_pend) chk("arvalid_hold", m_arvalid, 1'b1);
                if (is_wr && m_arvalid) saw_ar = 1;
                chk("wait", axi_wait, (axi_rd_en | axi_wr_en) && !done_now);
                if (done_now) begin
                    chk("done_fault", axi_access_fault, v.exp_fault);
                    chk("done_rd_data", axi_rd_data, v.exp_rd);
                    chk("latency", cyc, v.exp_lat);
                    chk("aw_count", aw_n, is_wr ? 1 : 0);
                    chk("w_count", w_n, is_wr ? 1 : 0);
                    chk("ar_count", ar_n, is_wr ? 0 : 1);
                    chk("ar_seen_on_write", saw_ar, 1'b0);
                    model_rd = v.exp_rd;
                    finished = 1;
                end else begin
                    chk("fault_idle", axi_access_fault, 1'b0);
                    chk("rd_data_hold", axi_rd_data, model_rd);
                end
                if (m_awvalid && m_awready) begin
                    aw_n++;
                    chk("awaddr", m_awaddr, v.addr);
                end else if (m_awvalid) aw_c++;
                if (m_wvalid && m_wready) begin
                    w_n++;
                    chk("wdata", m_wdata, v.wdata);
                    chk("wstrb", m_wstrb, v.strb);
                end else if (m_wvalid) w_c++;
                if (m_arvalid && m_arready) begin
                    ar_n++;
                    chk("araddr", m_araddr, v.addr);
                end else if (m_arvalid) ar_c++;
                aw_pend = m_awvalid && !m_awready;
                w_pend  = m_wvalid && !m_wready;
                ar_pend = m_arvalid && !m_arready;
                if (phase && resp_n == 0 && !rv) r_c++;
                if ((m_bvalid && m_bready) || (m_rvalid && m_rready)) begin
                    resp_n++;
                    if (hs_cyc < 0) hs_cyc = cyc;
                end
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done addr=%h", v.addr);
        end
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        int k;
        // rd wr addr wdata strb rdata resp aw w ar r drop rst fault exp_rd lat
        tbl[0] = mk(1, 0, 32'h1000, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 0, -1, 0, 32'hDEADBEEF, 3);
        tbl[1] = mk(0, 1, 32'h2004, 32'h12345678, 4'hF, 32'h0, 2'b00, 0, 2, 0, 0, 0, -1, 0, 32'hDEADBEEF, 5);
        tbl[2] = mk(1, 0, 32'h3000, 32'h0, 4'h0, 32'hCAFEF00D, 2'b11, 0, 0, 0, 1, 0, -1, 1, 32'hCAFEF00D, 4);
        tbl[3] = mk(1, 0, 32'h10, 32'h0, 4'h0, 32'h11111111, 2'b00, 0, 0, 0, 0, 0, -1, 0, 32'h11111111, 3);
        tbl[4] = mk(1, 0, 32'h14, 32'h0, 4'h0, 32'h22222222, 2'b00, 0, 0, 0, 0, 0, -1, 0, 32'h22222222, 3);
        tbl[5] = mk(1, 1, 32'h40, 32'hA5A5A5A5, 4'h5, 32'h0, 2'b10, 1, 0, 0, 2, 0, -1, 1, 32'h22222222, 6);
        tbl[6] = mk(1, 0, 32'h50, 32'h0, 4'h0, 32'h99999999, 2'b00, 0, 0, 0, 6, 0, 3, 0, 32'h0, -1);
        tbl[7] = mk(1, 0, 32'h60, 32'h0, 4'h0, 32'h33333333, 2'b00, 0, 0, 0, 0, 0, -1, 0, 32'h33333333, 3);
        tbl[8] = mk(0, 1, 32'h70, 32'h55AA55AA, 4'h3, 32'h0, 2'b10, 1, 1, 0, 1, 1, -1, 1, 32'h33333333, 5);
        tbl[9] = mk(1, 0, 32'h80, 32'h0, 4'h0, 32'h44444444, 2'b01, 0, 0, 2, 0, 1, -1, 0, 32'h44444444, 5);

        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        chk("reset_rd_data", axi_rd_data, 32'h0);
        chk("reset_fault", axi_access_fault, 1'b0);
        chk("reset_wait", axi_wait, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 2);
            v.rd_en = (k != 1);
            v.wr_en = (k != 0);
            v.addr = $urandom & 32'hFFFF_FFFC;
            v.wdata = $urandom;
            v.strb = 4'($urandom_range(0, 15));
            v.rdata = $urandom;
            v.resp = 2'($urandom_range(0, 3));
            v.aw_d = $urandom_range(0, 3);
            v.w_d = $urandom_range(0, 3);
            v.ar_d = $urandom_range(0, 3);
            v.r_d = $urandom_range(0, 3);
            v.drop = ($urandom_range(0, 5) == 0);
            v.rst_cyc = -1;
            v.exp_fault = v.resp[1];
            v.exp_rd = v.wr_en ? model_rd : v.rdata;
            v.exp_lat = v.wr_en ? 3 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.r_d
                                : 3 + v.ar_d + v.r_d;
            run(v);
        end

        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default DEFAULT_AXI_ADDR_WIDTH, byte address width of the AXI space.
REQ-002 SHALL use one clock and an asynchronous, active-low reset, exactly: clk  in  1  global system clock.
REQ-003 rst_n  in  1  global reset, asynchronous, active-low.
REQ-004 axi_rd_en  in  1  core read request (level).
REQ-005 axi_wr_en  in  1  core write request (level).
REQ-006 axi_addr  in  AXI_ADDR_WIDTH  core byte address.
REQ-007 wr_data  in  32  core write data.
REQ-008 wr_strobe  in  4  core byte-lane strobe.
REQ-009 axi_rd_data  out  32  read data to core.
REQ-010 axi_access_fault  out  1  error response to core.
REQ-011 axi_wait  out  1  stall request to core.
REQ-012 m_awaddr  out  AXI_ADDR_WIDTH  write address.
REQ-013 m_awvalid  out  1;  m_awready  in  1.
REQ-014 m_wdata  out  32;  m_wstrb  out  4.
REQ-015 m_wvalid  out  1;  m_wready  in  1.
REQ-016 m_bresp  in  2;  m_bvalid  in  1;  m_bready  out  1.
REQ-017 m_araddr  out  AXI_ADDR_WIDTH  read address.
REQ-018 m_arvalid  out  1;  m_arready  in  1.
REQ-019 m_rdata  in  32;  m_rresp  in  2;  m_rvalid  in  1;  m_rready  out  1.

Function
REQ-020 SHALL implement FSM IDLE, ADDR, RESP, DONE; one transaction outstanding at most.
REQ-021 IDLE: on axi_wr_en or axi_rd_en, SHALL register addr/data/strobe/direction and enter ADDR; wr_en wins if both are high.
REQ-022 axi_wait SHALL be combinational: high when (axi_rd_en|axi_wr_en) and state!=DONE, including the IDLE cycle of acceptance; low otherwise.
REQ-023 ADDR write: m_awvalid and m_wvalid SHALL assert together; each drops after its own handshake (independent aw_done/w_done flags); enter RESP once both are done, the same cycle the second handshake occurs.
REQ-024 ADDR read: m_arvalid SHALL assert until m_arready; then enter RESP.
REQ-025 RESP: m_bready (write) or m_rready (read) SHALL be high; on valid, capture m_rdata (reads only) and resp[1], then enter DONE.
REQ-026 DONE SHALL last exactly one cycle: axi_wait=0, axi_rd_data=captured data, axi_access_fault=captured resp[1] (SLVERR/DECERR); then IDLE.
REQ-027 axi_access_fault SHALL be 0 outside DONE; axi_rd_data SHALL hold its last captured value; write transactions SHALL NOT update it.
REQ-028 Minimum latency with ready/valid tied high: request in cycle 0, DONE in cycle 3.
REQ-029 A launched transaction SHALL complete even if the core request drops; DONE output is then ignored, and no new request is accepted before IDLE.
REQ-030 Valid outputs SHALL be registered, and SHALL NOT drop before their handshake.

Reset
REQ-031 On rst_n low, at any time including mid-transaction: state=IDLE; all m_*valid/ready=0; registered addr/data/strobe=0; axi_rd_data=0; fault flags=0.

Structure
REQ-032 axi_resp_t (OKAY, EXOKAY, SLVERR, DECERR) and the FSM state enum SHALL live in package lexington; no sub-module.

Verification
REQ-033 Read 0x1000, all ready=1, rvalid next cycle with rdata=0xDEADBEEF, rresp=OKAY -> axi_wait 1,1,1,0; DONE rd_data=0xDEADBEEF, fault=0.
REQ-034 Write 0x2004, data 0x12345678, strb 0xF; awready 2 cycles before wready -> aw/w each handshake once; bvalid OKAY -> one DONE cycle, fault=0.
REQ-035 Read with rresp=DECERR -> DONE asserts fault=1 for exactly one cycle; rd_data updated.
REQ-036 Back-to-back reads 0x10, 0x14 -> two separate AR handshakes, IDLE cycle between, no duplicate AR.
REQ-037 rst_n low while in RESP -> all valids/readies low immediately, state IDLE, axi_rd_data=0.
REQ-038 rd_en and wr_en both high -> write issued, arvalid never asserted.
